// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; each runs WIDTH steps plus one sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [5:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               negProd;
    logic               negQuo;
    logic               negRem;
    logic               opIsDiv;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    logic               isMulOp;
    logic               isDivOp;
    logic               isSignedOp;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divTrial;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] fixSign(input logic neg, input logic signed [WIDTH-1:0] v);
        return neg ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fixSignWide(input logic neg,
                                                       input logic signed [2*WIDTH-1:0] v);
        return neg ? (2*WIDTH)'(-v) : v;
    endfunction

    assign isMulOp    = (operation == OP_MULT) || (operation == OP_MULTU);
    assign isDivOp    = (operation == OP_DIV)  || (operation == OP_DIVU);
    assign isSignedOp = (operation == OP_MULT) || (operation == OP_DIV);

    // One extra bit catches the carry out of the upper-half add before the right shift.
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    assign divShift = {rem, quo[WIDTH-1]};
    assign divTrial = divShift - {1'b0, divisor};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            divByZero <= 1'b0;
            negProd   <= 1'b0;
            negQuo    <= 1'b0;
            negRem    <= 1'b0;
            opIsDiv   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (operation)
                            OP_MTHI: begin
                                hi        <= a;
                                divByZero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo        <= a;
                                divByZero <= 1'b0;
                            end
                            OP_MULT, OP_MULTU: begin
                                divByZero <= 1'b0;
                                negProd   <= isSignedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                                opIsDiv   <= 1'b0;
                                counter   <= CNT_W'(WIDTH - 1);
                                busy      <= 1'b1;
                                state     <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    divByZero <= 1'b1;
                                    hi        <= a;
                                    lo        <= '1;
                                    done      <= 1'b1;
                                end else begin
                                    divByZero <= 1'b0;
                                    negQuo    <= isSignedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    negRem    <= isSignedOp & a[WIDTH-1];
                                    opIsDiv   <= 1'b1;
                                    counter   <= CNT_W'(WIDTH - 1);
                                    busy      <= 1'b1;
                                    state     <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (counter == '0) begin
                        state <= FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                FIX: begin
                    if (opIsDiv) begin
                        hi <= fixSign(negRem, rem);
                        lo <= fixSign(negQuo, quo);
                    end else begin
                        {hi, lo} <= fixSignWide(negProd, acc);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers: only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && isMulOp) begin
            mcand  <= isSignedOp ? magnitude(a) : a;
            mplier <= isSignedOp ? magnitude(b) : b;
            acc    <= '0;
        end else if (state == IDLE && start && isDivOp) begin
            quo     <= isSignedOp ? magnitude(a) : a;
            divisor <= isSignedOp ? magnitude(b) : b;
            rem     <= '0;
        end else if (state == MUL) begin
            acc    <= {mulSum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end else if (state == DIV) begin
            if (!divTrial[WIDTH]) begin
                rem <= divTrial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= divShift[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written corner sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [5:0]  operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .resetN(resetN), .start(start), .operation(operation),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
        bit          dz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from plain 64-bit arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] eh, output logic [31:0] el,
                         output int ecyc, output bit edz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ecyc = 33;
        edz = 1'b0;
        eh = '0;
        el = '0;
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, ia} * {32'b0, ib};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (ib == 32'd0) begin
                    eh = ia;
                    el = 32'hFFFF_FFFF;
                    ecyc = 0;
                    edz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = 64'(q);
                    el = p[31:0];
                    p = 64'(r);
                    eh = p[31:0];
                end else begin
                    el = ia / ib;
                    eh = ia % ib;
                end
            end
        endcase
    endtask

    // Entered and left at a falling edge; leaves with done high so the next call is back-to-back.
    task automatic doOp(input string tag, input logic [5:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input bit edz);
        int cyc;
        bit got;
        bit overlap;
        cyc = 0;
        got = 1'b0;
        overlap = 1'b0;
        start = 1'b1;
        operation = op;
        a = ia;
        b = ib;
        @(negedge clk);
        start = 1'b0;
        operation = 6'($urandom);
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 40; i++) begin
            if (done && busy) overlap = 1'b1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
        check($sformatf("%s done seen", tag), 32'(got), 32'd1);
        check($sformatf("%s busy cycles", tag), 32'(cyc), 32'(ecyc));
        check($sformatf("%s done/busy overlap", tag), 32'(overlap), 32'd0);
        check($sformatf("%s hi", tag), hi, eh);
        check($sformatf("%s lo", tag), lo, el);
        check($sformatf("%s divByZero", tag), 32'(divByZero), 32'(edz));
    endtask

    initial begin
        logic [31:0] eh, el, prevHi, prevLo;
        int          ecyc;
        bit          edz;
        logic [5:0]  rop;
        int          sawDone;
        int          sawBusy;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0};
        vecs[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 1'b0};
        vecs[5] = '{OP_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0,  1'b1};
        vecs[6] = '{OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        33, 1'b0};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         33, 1'b0};

        resetN = 1'b0;
        start = 1'b0;
        operation = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset divByZero", 32'(divByZero), 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].eh, vecs[i].el, vecs[i].cyc, vecs[i].dz);
        end
        @(negedge clk);
        check("done single pulse", 32'(done), 32'd0);

        // A start while busy must be ignored, and hi/lo must hold until the fix edge.
        prevHi = hi;
        prevLo = lo;
        start = 1'b1; operation = OP_MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; operation = OP_MTHI; a = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy-start hi held", hi, prevHi);
        check("busy-start lo held", lo, prevLo);
        sawDone = 0;
        for (int i = 0; i < 40 && sawDone == 0; i++) begin
            if (done) sawDone = 1;
            else @(negedge clk);
        end
        check("busy-start done", 32'(sawDone), 32'd1);
        check("busy-start hi", hi, 32'd0);
        check("busy-start lo", lo, 32'd30);

        @(negedge clk);
        start = 1'b1; operation = OP_MTLO; a = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("MTLO lo", lo, 32'h0000_1234);
        check("MTLO done", 32'(done), 32'd0);
        check("MTLO busy", 32'(busy), 32'd0);
        start = 1'b1; operation = OP_MTHI; a = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0;
        check("MTHI hi", hi, 32'h0000_AAAA);
        check("MTHI done", 32'(done), 32'd0);
        start = 1'b1; operation = 6'b111111; a = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        check("bad op busy", 32'(busy), 32'd0);
        check("bad op hi", hi, 32'h0000_AAAA);
        check("bad op lo", lo, 32'h0000_1234);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            case ($urandom_range(0, 3))
                0: rop = OP_MULT;
                1: rop = OP_MULTU;
                2: rop = OP_DIV;
                default: rop = OP_DIVU;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            model(rop, ra, rb, eh, el, ecyc, edz);
            doOp($sformatf("rand%0d", n), rop, ra, rb, eh, el, ecyc, edz);
        end

        // Asynchronous reset mid-operation discards the in-flight result.
        @(negedge clk);
        start = 1'b1; operation = OP_MULT; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        check("async reset done", 32'(done), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        sawDone = 0;
        sawBusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) sawDone++;
            if (busy) sawBusy++;
        end
        check("post-reset no done", 32'(sawDone), 32'd0);
        check("post-reset no busy", 32'(sawBusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
